// File: rtl/bomb_game_ctrl.sv
// Bomb game sequencer: latches the secret code and defuse time, steers the
// countdown timer through arming and defusing, and judges defuse attempts.
module bomb_game_ctrl #(
  parameter int ARM_TIME       = 5,
  parameter int DEFAULT_DEFUSE = 10,
  parameter int MAX_DEFUSE     = 20,
  parameter int MAX_TRIES      = 3
) (
  input  logic       clk,
  input  logic       sw7,
  input  logic       btn_confirm,
  input  logic [3:0] pwd_in,
  input  logic [4:0] time_set,
  input  logic [1:0] countdown_state,
  output logic [1:0] game_state,
  output logic [4:0] countdown_times,
  output logic       boom,
  output logic       defused,
  output logic [1:0] tries_left,
  output logic       pwd_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_DEFUSE = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t     r_state,   w_state_n;
  logic [4:0] r_cnt,     w_cnt_n;
  logic       r_boom,    w_boom_n;
  logic       r_def,     w_def_n;
  logic [1:0] r_tries,   w_tries_n;
  logic       r_err,     w_err_n;
  logic [3:0] r_secret,  w_secret_n;
  logic [4:0] r_dt,      w_dt_n;
  logic       r_seen,    w_seen_n;
  logic       r_btn_q;

  logic       w_press;
  logic       w_expiry;
  logic [4:0] w_dt_clamp;

  assign w_press  = btn_confirm & ~r_btn_q;
  // Timer reads 0 both before it starts and after it finishes; only the
  // latter counts, hence the seen_run qualifier.
  assign w_expiry = r_seen & (countdown_state == 2'd0);

  assign w_dt_clamp = (time_set == '0)              ? 5'(DEFAULT_DEFUSE) :
                      (time_set > 5'(MAX_DEFUSE))   ? 5'(MAX_DEFUSE)     :
                                                      time_set;

  // State and datapath registers; sw7 low forces everything to reset values.
  always_ff @(posedge clk or negedge sw7) begin
    if (!sw7) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_boom   <= 1'b0;
      r_def    <= 1'b0;
      r_tries  <= 2'(MAX_TRIES);
      r_err    <= 1'b0;
      r_secret <= '0;
      r_dt     <= '0;
      r_seen   <= 1'b0;
      r_btn_q  <= 1'b1;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_boom   <= w_boom_n;
      r_def    <= w_def_n;
      r_tries  <= w_tries_n;
      r_err    <= w_err_n;
      r_secret <= w_secret_n;
      r_dt     <= w_dt_n;
      r_seen   <= w_seen_n;
      r_btn_q  <= btn_confirm;
    end
  end

  // Next-state and next-output decisions for the game sequence.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_boom_n   = r_boom;
    w_def_n    = r_def;
    w_tries_n  = r_tries;
    w_err_n    = 1'b0;
    w_secret_n = r_secret;
    w_dt_n     = r_dt;
    w_seen_n   = r_seen;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (w_press) begin
          w_secret_n = pwd_in;
          w_dt_n     = w_dt_clamp;
          w_tries_n  = 2'(MAX_TRIES);
          w_state_n  = S_ARM;
          w_cnt_n    = 5'(ARM_TIME);
        end
      end
      S_ARM: begin
        w_cnt_n = 5'(ARM_TIME);
        if (countdown_state == 2'd2) begin
          w_state_n = S_DEFUSE;
          w_cnt_n   = r_dt;
          w_seen_n  = 1'b0;
        end
      end
      S_DEFUSE: begin
        w_cnt_n = r_dt;
        if (countdown_state == 2'd3) w_seen_n = 1'b1;
        // Expiry outranks any press in the same cycle.
        if (w_expiry) begin
          w_state_n = S_END;
          w_boom_n  = 1'b1;
          w_cnt_n   = '0;
        end else if (w_press) begin
          if (pwd_in == r_secret) begin
            w_state_n = S_END;
            w_def_n   = 1'b1;
            w_cnt_n   = '0;
          end else begin
            w_err_n = 1'b1;
            if (r_tries <= 2'd1) begin
              w_tries_n = '0;
              w_state_n = S_END;
              w_boom_n  = 1'b1;
              w_cnt_n   = '0;
            end else begin
              w_tries_n = r_tries - 2'd1;
            end
          end
        end
      end
      S_END: begin
        w_cnt_n = '0;
        if (w_press) begin
          w_state_n = S_IDLE;
          w_boom_n  = 1'b0;
          w_def_n   = 1'b0;
          w_seen_n  = 1'b0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign game_state      = r_state;
  assign countdown_times = r_cnt;
  assign boom            = r_boom;
  assign defused         = r_def;
  assign tries_left      = r_tries;
  assign pwd_err         = r_err;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Self-checking bench for bomb_game_ctrl: a cycle-level game model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bomb_game_ctrl;

  logic       clk = 1'b0;
  logic       sw7 = 1'b1;
  logic       btn_confirm = 1'b1;
  logic [3:0] pwd_in = '0;
  logic [4:0] time_set = '0;
  logic [1:0] countdown_state = '0;
  logic [1:0] game_state;
  logic [4:0] countdown_times;
  logic       boom, defused, pwd_err;
  logic [1:0] tries_left;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  bomb_game_ctrl #(
    .ARM_TIME(5), .DEFAULT_DEFUSE(10), .MAX_DEFUSE(20), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .sw7(sw7), .btn_confirm(btn_confirm), .pwd_in(pwd_in),
    .time_set(time_set), .countdown_state(countdown_state),
    .game_state(game_state), .countdown_times(countdown_times),
    .boom(boom), .defused(defused), .tries_left(tries_left), .pwd_err(pwd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase, loaded seconds, result flags, attempts left.
  int  m_gs, m_cnt, m_boom, m_def, m_tries, m_err, m_secret, m_dt, m_seen, m_prev_btn;

  task automatic model_reset();
    m_gs = 0; m_cnt = 0; m_boom = 0; m_def = 0; m_tries = 3; m_err = 0;
    m_secret = 0; m_dt = 0; m_seen = 0; m_prev_btn = 1;
  endtask

  initial model_reset();

  always @(posedge clk or negedge sw7) begin
    if (!sw7) begin
      model_reset();
    end else begin
      int  ts, cs;
      bit  pressed, timed_out;
      ts = int'(time_set);
      cs = int'(countdown_state);
      pressed = (btn_confirm == 1'b1) && (m_prev_btn == 0);
      m_prev_btn = int'(btn_confirm);
      m_err = 0;
      if (m_gs == 0) begin
        m_cnt = 0;
        if (pressed) begin
          m_secret = int'(pwd_in);
          m_dt = (ts == 0) ? 10 : (ts > 20 ? 20 : ts);
          m_tries = 3; m_gs = 1; m_cnt = 5;
        end
      end else if (m_gs == 1) begin
        m_cnt = 5;
        if (cs == 2) begin m_gs = 2; m_cnt = m_dt; m_seen = 0; end
      end else if (m_gs == 2) begin
        m_cnt = m_dt;
        timed_out = (m_seen == 1) && (cs == 0);
        if (cs == 3) m_seen = 1;
        if (timed_out) begin
          m_gs = 3; m_boom = 1; m_cnt = 0;
        end else if (pressed) begin
          if (int'(pwd_in) == m_secret) begin
            m_gs = 3; m_def = 1; m_cnt = 0;
          end else begin
            m_err = 1;
            m_tries = m_tries - 1;
            if (m_tries == 0) begin m_gs = 3; m_boom = 1; m_cnt = 0; end
          end
        end
      end else begin
        m_cnt = 0;
        if (pressed) begin m_gs = 0; m_boom = 0; m_def = 0; m_seen = 0; end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_game_state", int'(game_state), m_gs);
      chk("cyc_countdown_times", int'(countdown_times), m_cnt);
      chk("cyc_boom", int'(boom), m_boom);
      chk("cyc_defused", int'(defused), m_def);
      chk("cyc_tries_left", int'(tries_left), m_tries);
      chk("cyc_pwd_err", int'(pwd_err), m_err);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic press();
    btn_confirm = 1'b1; step();
  endtask

  task automatic release_btn();
    btn_confirm = 1'b0; step();
  endtask

  initial begin
    // Assert reset with the key held, before the first clock edge.
    #1 sw7 = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_game_state", int'(game_state), 0);
    chk("rst_tries_left", int'(tries_left), 3);
    step(2);
    sw7 = 1'b1;
    step(2);
    chk("held_key_no_start", int'(game_state), 0);
    chk("held_key_tries", int'(tries_left), 3);
    release_btn();

    // countdown_state 2 in IDLE is ignored.
    countdown_state = 2'd2; step();
    chk("idle_ignores_cs2", int'(game_state), 0);
    countdown_state = 2'd0;

    // Arm path.
    pwd_in = 4'hA; time_set = 5'd8;
    press();
    chk("arm_state", int'(game_state), 1);
    chk("arm_times", int'(countdown_times), 5);
    release_btn();
    press();
    chk("arm_ignores_press", int'(game_state), 1);
    release_btn();
    countdown_state = 2'd1; step(2);
    countdown_state = 2'd2; step();
    chk("defuse_state", int'(game_state), 2);
    chk("defuse_times", int'(countdown_times), 8);

    // Defuse success then return to IDLE.
    countdown_state = 2'd3; step();
    press();
    chk("ok_state", int'(game_state), 3);
    chk("ok_defused", int'(defused), 1);
    chk("ok_boom", int'(boom), 0);
    chk("ok_times", int'(countdown_times), 0);
    release_btn();
    press();
    chk("back_idle", int'(game_state), 0);
    chk("back_flags", int'({boom, defused}), 0);
    release_btn();
    countdown_state = 2'd0;

    // Three wrong codes.
    pwd_in = 4'hA; time_set = 5'd8;
    press(); release_btn();
    countdown_state = 2'd2; step();
    countdown_state = 2'd3; step();
    pwd_in = 4'h3;
    for (int i = 0; i < 3; i++) begin
      press();
      chk("wrong_err_pulse", int'(pwd_err), 1);
      chk("wrong_tries", int'(tries_left), 2 - i);
      release_btn();
      chk("wrong_err_drop", int'(pwd_err), 0);
    end
    chk("wrong_end", int'(game_state), 3);
    chk("wrong_boom", int'(boom), 1);
    press(); release_btn();
    countdown_state = 2'd0;

    // Default time and timeout.
    pwd_in = 4'h5; time_set = 5'd0;
    press(); release_btn();
    countdown_state = 2'd2; step();
    chk("default_times", int'(countdown_times), 10);
    countdown_state = 2'd3; step(2);
    countdown_state = 2'd0; step();
    chk("timeout_end", int'(game_state), 3);
    chk("timeout_boom", int'(boom), 1);
    press(); release_btn();

    // Clamp, then expiry racing a correct press.
    time_set = 5'd31;
    press(); release_btn();
    countdown_state = 2'd2; step();
    chk("clamp_times", int'(countdown_times), 20);
    countdown_state = 2'd3; step();
    countdown_state = 2'd0; btn_confirm = 1'b1; step();
    chk("race_boom", int'(boom), 1);
    chk("race_defused", int'(defused), 0);
    release_btn();
    press(); release_btn();

    // Boundary: time_set exactly at the clamp limit is kept.
    time_set = 5'd20;
    press(); release_btn();
    countdown_state = 2'd2; step();
    chk("limit_times", int'(countdown_times), 20);

    // Async reset mid-DEFUSE, between edges.
    countdown_state = 2'd3;
    pwd_in = 4'h1; press();
    chk("pre_rst_tries", int'(tries_left), 2);
    btn_confirm = 1'b0;
    @(posedge clk); #3;
    sw7 = 1'b0;
    #1;
    chk("arst_game_state", int'(game_state), 0);
    chk("arst_times", int'(countdown_times), 0);
    chk("arst_flags", int'({boom, defused, pwd_err}), 0);
    chk("arst_tries", int'(tries_left), 3);
    countdown_state = 2'd0;
    step(2);
    sw7 = 1'b1;
    step(3);
    chk("post_rst_idle", int'(game_state), 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bomb_game_ctrl.md
Name: bomb_game_ctrl

Overview:
- Top-level game sequencer for the bomb game.
- Latches the player's secret code and defuse time, then drives game_state and countdown_times into the countdown timer.
- Watches countdown_state from that timer to advance the game.
- Judges defuse attempts and produces the final BOOM / DEFUSED result for LEDs and display.

Parameters:
- ARM_TIME, 5, seconds loaded into the countdown during the arming phase.
- DEFAULT_DEFUSE, 10, defuse seconds used when time_set is 0 at confirm.
- MAX_DEFUSE, 20, upper clamp for time_set.
- MAX_TRIES, 3, wrong codes allowed before immediate boom (1..3).

Ports:
- clk  input  1  system clock (1 MHz; shared with countdown timer)
- sw7  input  1  game enable; asynchronous active-low reset (low = game off)
- btn_confirm  input  1  debounced confirm key, level; module edge-detects
- pwd_in  input  4  code switches
- time_set  input  5  defuse time switches, seconds
- countdown_state  input  2  status from countdown timer (0 idle, 1 arming run, 2 arm done, 3 defuse run)
- game_state  output  2  0 IDLE, 1 ARM, 2 DEFUSE, 3 END
- countdown_times  output  5  seconds for the timer to load
- boom  output  1  high in END after explosion
- defused  output  1  high in END after successful defuse
- tries_left  output  2  remaining wrong-code allowance
- pwd_err  output  1  one-cycle pulse on wrong code

Behaviour:
- Reset (sw7 low, async): game_state=0, countdown_times=0, boom=0, defused=0, tries_left=MAX_TRIES, pwd_err=0, secret=0, defuse_time=0, seen_run=0, btn_q=1. btn_q=1 means a key held through reset produces no edge.
- Confirm edge: press = btn_confirm & ~btn_q; btn_q registered every cycle. Levels are never acted on.
- IDLE:
  - countdown_times=0.
  - On press: secret<=pwd_in; defuse_time<=DEFAULT_DEFUSE if time_set==0, MAX_DEFUSE if time_set>MAX_DEFUSE, else time_set.
  - Same press: tries_left<=MAX_TRIES; go to ARM with countdown_times=ARM_TIME.
- ARM:
  - Hold countdown_times=ARM_TIME.
  - Presses ignored.
  - When countdown_state==2: go to DEFUSE, countdown_times<=defuse_time, seen_run<=0.
- DEFUSE:
  - Hold countdown_times=defuse_time.
  - seen_run<=1 when countdown_state==3.
  - Expiry = seen_run & countdown_state==0; on expiry: END, boom=1.
  - Press with pwd_in==secret: END, defused=1.
  - Press with pwd_in!=secret: pwd_err pulses 1 cycle; tries_left-1. If tries_left was 1: END, boom=1, tries_left=0.
  - Same-cycle expiry and correct press: expiry wins (boom=1, defused=0).
- END:
  - countdown_times=0 (timer self-clears when game_state==3).
  - boom/defused held, mutually exclusive.
  - Press returns to IDLE; clears boom, defused, seen_run; secret retained until the next IDLE latch.
- All outputs registered; every transition takes 1 cycle after the qualifying input is sampled.
- countdown_state values not listed for the current state are ignored, e.g. a 2 seen in IDLE.
- sw7 low mid-game: immediate return to reset values; the timer is cleared by the same switch.

Test Plan:
- Reset/enable: sw7=0 with btn held, release sw7 while btn still high -> no transition; game_state=0, tries_left=3.
- Arm path: pwd_in=4'hA, time_set=8, press -> game_state=1, countdown_times=5. Force countdown_state 0→1→2 -> next cycle game_state=2, countdown_times=8.
- Defuse success: in DEFUSE with countdown_state=3, pwd_in=4'hA, press -> game_state=3, defused=1, boom=0. Press again -> game_state=0, flags cleared.
- Wrong codes: three presses with pwd_in=4'h3 -> pwd_err pulses x3; tries_left 3→2→1→0; third press gives game_state=3, boom=1.
- Timeout and clamp: time_set=0 -> countdown_times=10 in DEFUSE. Then time_set=31 on a new game -> 20. countdown_state 3→0 -> boom=1. Expiry same cycle as a correct press -> boom=1, defused=0.
- Async reset mid-DEFUSE: drop sw7 between clock edges -> all outputs at reset values before the next edge.
